// File: rtl/score_board_s_pkg.sv
// Shared definitions for the scoreboard game-state stage.
// Contents:
//   state_e          - half-inning FSM encoding (TOP, BOT, OVER)
//   BCD_MAX          - two-digit BCD saturation value (99)
//   BASE_FORCED      - base code that forces a runner home on an advance
//   bcd_inc_sat()    - saturating two-digit BCD increment
//   bcd_gt()         - two-digit BCD magnitude compare, tens digit first
package score_board_s_pkg;

    typedef enum logic [1:0] {
        ST_TOP  = 2'd0,
        ST_BOT  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [7:0] BCD_MAX     = 8'h99;
    localparam logic [2:0] BASE_FORCED = 3'b111;

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_gt(input logic [7:0] a, input logic [7:0] b);
        logic r;
        if (a[7:4] != b[7:4]) begin
            r = (a[7:4] > b[7:4]);
        end else begin
            r = (a[3:0] > b[3:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/score_board_s_bcd_counter2.sv
// Two-digit BCD run counter that saturates at 99.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset (count -> 00)
//   inc_en - add one run this cycle
//   count  - current count, two BCD digits
module bcd_counter2_s
    import score_board_s_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_en,
    output logic [7:0] count
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = bcd_inc_sat(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/score_board_s.sv
// Game-state stage: turns forced-run advances and side-outs into BCD scores,
// inning/half tracking and game-over detection for the display stage.
// Ports:
//   iCLK, iRST          - clock, synchronous active-high reset
//   iADVANCE, iBASE     - batter-reaches-base pulse and pre-advance occupancy
//   iSIDE_OUT           - third-out pulse
//   oAWAY_SCORE/oHOME_SCORE - BCD runs
//   oINNING, oTOP       - current inning (binary) and half (1 = top)
//   oRUN                - registered pulse one cycle after a scoring advance
//   oGAME_OVER          - high once the game has ended
//
// state | meaning
// TOP   | away team batting
// BOT   | home team batting
// OVER  | game ended; inputs ignored until reset
module score_board_s
    import score_board_s_pkg::*;
#(
    parameter int MAX_INNING  = 12,
    parameter int REG_INNINGS = 9
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iADVANCE,
    input  logic [2:0] iBASE,
    input  logic       iSIDE_OUT,
    output logic [7:0] oAWAY_SCORE,
    output logic [7:0] oHOME_SCORE,
    output logic [3:0] oINNING,
    output logic       oTOP,
    output logic       oRUN,
    output logic       oGAME_OVER
);

    localparam logic [3:0] REG_L = 4'(REG_INNINGS);
    localparam logic [3:0] MAX_L = 4'(MAX_INNING);

    state_e     state_q, state_d;
    logic [3:0] inning_q, inning_d;
    logic       top_q, top_d;
    logic       run_q, run_d;
    logic       over_q, over_d;

    logic       run_hit;
    logic       away_inc;
    logic       home_inc;
    logic       late_game;
    logic [7:0] away_next;
    logic [7:0] home_next;

    bcd_counter2_s u_away (
        .clk    (iCLK),
        .rst    (iRST),
        .inc_en (away_inc),
        .count  (oAWAY_SCORE)
    );

    bcd_counter2_s u_home (
        .clk    (iCLK),
        .rst    (iRST),
        .inc_en (home_inc),
        .count  (oHOME_SCORE)
    );

    // Scores as they will be after this edge, so a run and a side-out in the
    // same cycle are judged on the updated score.
    always_comb begin
        run_hit   = iADVANCE && (iBASE == BASE_FORCED) && (state_q != ST_OVER);
        away_inc  = run_hit && (state_q == ST_TOP);
        home_inc  = run_hit && (state_q == ST_BOT);
        away_next = away_inc ? bcd_inc_sat(oAWAY_SCORE) : oAWAY_SCORE;
        home_next = home_inc ? bcd_inc_sat(oHOME_SCORE) : oHOME_SCORE;
        late_game = (inning_q >= REG_L);
    end

    always_comb begin
        state_d  = state_q;
        inning_d = inning_q;
        top_d    = top_q;
        run_d    = run_hit;
        case (state_q)
            ST_TOP: begin
                if (iSIDE_OUT) begin
                    if (late_game && bcd_gt(oHOME_SCORE, away_next)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_BOT;
                        top_d   = 1'b0;
                    end
                end
            end
            ST_BOT: begin
                // A walk-off ends the game on the scoring edge; a coincident
                // side-out is then irrelevant.
                if (late_game && home_inc && bcd_gt(home_next, oAWAY_SCORE)) begin
                    state_d = ST_OVER;
                end else if (iSIDE_OUT) begin
                    if (late_game && (home_next != oAWAY_SCORE)) begin
                        state_d = ST_OVER;
                    end else if (inning_q == MAX_L) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d  = ST_TOP;
                        inning_d = inning_q + 4'd1;
                        top_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_OVER;
                run_d   = 1'b0;
            end
        endcase
        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_TOP;
            inning_q <= 4'd1;
            top_q    <= 1'b1;
            run_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            inning_q <= inning_d;
            top_q    <= top_d;
            run_q    <= run_d;
            over_q   <= over_d;
        end
    end

    assign oINNING    = inning_q;
    assign oTOP       = top_q;
    assign oRUN       = run_q;
    assign oGAME_OVER = over_q;

endmodule

// File: tb/tb_score_board_s.sv
module tb_score_board_s;

    logic       clk;
    logic       rst;
    logic       adv;
    logic [2:0] base;
    logic       side;
    logic [7:0] away;
    logic [7:0] home;
    logic [3:0] inning;
    logic       top;
    logic       run;
    logic       over;

    int checks   = 0;
    int failures = 0;

    score_board_s #(.MAX_INNING(12), .REG_INNINGS(9)) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iADVANCE    (adv),
        .iBASE       (base),
        .iSIDE_OUT   (side),
        .oAWAY_SCORE (away),
        .oHOME_SCORE (home),
        .oINNING     (inning),
        .oTOP        (top),
        .oRUN        (run),
        .oGAME_OVER  (over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       adv;
        logic [2:0] base;
        logic       side;
        logic [7:0] ea;
        logic [7:0] eh;
        logic [3:0] ei;
        logic       et;
        logic       er;
        logic       eo;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    // Drive one cycle of inputs, let the edge take them, sample 1ns later.
    task automatic step(input logic r, input logic a, input logic [2:0] b, input logic s);
        rst  = r;
        adv  = a;
        base = b;
        side = s;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        adv  = 1'b0;
        base = 3'b000;
        side = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] ea, input logic [7:0] eh,
                       input logic [3:0] ei, input logic et, input logic er, input logic eo);
        checks++;
        if (away !== ea || home !== eh || inning !== ei || top !== et || run !== er || over !== eo) begin
            failures++;
            $display("FAIL %s: got away=%h home=%h inning=%0d top=%b run=%b over=%b, want away=%h home=%h inning=%0d top=%b run=%b over=%b",
                     name, away, home, inning, top, run, over, ea, eh, ei, et, er, eo);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic runs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'b111, 1'b0);
    endtask

    task automatic sides(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 1'b1);
    endtask

    initial begin
        rst  = 1'b1;
        adv  = 1'b0;
        base = 3'b000;
        side = 1'b0;

        //          rst   adv   base    side  away   home   inn   top   run   over
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'b111, 1'b1, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b111, 1'b0, 8'h01, 8'h00, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 3'b000, 1'b0, 8'h01, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b011, 1'b0, 8'h01, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b101, 1'b0, 8'h01, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'b111, 1'b0, 8'h01, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'b000, 1'b1, 8'h01, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b111, 1'b0, 8'h01, 8'h01, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'b000, 1'b1, 8'h01, 8'h01, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b111, 1'b1, 8'h02, 8'h01, 4'd2, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'b000, 1'b1, 8'h02, 8'h01, 4'd3, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].adv, vecs[i].base, vecs[i].side);
            chk($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eh, vecs[i].ei,
                vecs[i].et, vecs[i].er, vecs[i].eo);
        end

        // Reset then long idle.
        do_reset();
        chk("reset", 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0);
            chk($sformatf("idle%0d", i), 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
        end

        // Half-inning flow with a 0-0 game into extra innings.
        sides(1);
        chk("half_1b", 8'h00, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
        sides(1);
        chk("half_2t", 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            sides(1);
            if (k == 14) chk("half_9b", 8'h00, 8'h00, 4'd9, 1'b0, 1'b0, 1'b0);
            if (k == 15) chk("half_10t_tied", 8'h00, 8'h00, 4'd10, 1'b1, 1'b0, 1'b0);
        end

        // Walk-off in bottom 9 from 2-2.
        do_reset();
        runs(2);
        sides(1);
        runs(2);
        sides(1);
        sides(15);
        chk("pre_walkoff", 8'h02, 8'h02, 4'd9, 1'b0, 1'b0, 1'b0);
        runs(1);
        chk("walkoff", 8'h02, 8'h03, 4'd9, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'b111, 1'b1);
        chk("over_hold_adv_side", 8'h02, 8'h03, 4'd9, 1'b0, 1'b0, 1'b1);
        sides(1);
        chk("over_hold_side", 8'h02, 8'h03, 4'd9, 1'b0, 1'b0, 1'b1);

        // Home leads after top 9: bottom not played.
        do_reset();
        runs(3);
        sides(1);
        runs(5);
        sides(1);
        sides(14);
        chk("pre_top9_end", 8'h03, 8'h05, 4'd9, 1'b1, 1'b0, 1'b0);
        sides(1);
        chk("top9_end", 8'h03, 8'h05, 4'd9, 1'b1, 1'b0, 1'b1);

        // Tie through bottom of the last inning.
        do_reset();
        sides(23);
        chk("pre_max_tie", 8'h00, 8'h00, 4'd12, 1'b0, 1'b0, 1'b0);
        sides(1);
        chk("max_tie_end", 8'h00, 8'h00, 4'd12, 1'b0, 1'b0, 1'b1);

        // Simultaneous run and side-out in top 1.
        do_reset();
        step(1'b0, 1'b1, 3'b111, 1'b1);
        chk("simul_top1", 8'h01, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0);

        // Saturation at 99, then mid-game reset.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            int n;
            n = (i + 1 > 99) ? 99 : i + 1;
            runs(1);
            chk($sformatf("sat_run%0d", i), to_bcd(n), 8'h00, 4'd1, 1'b1, 1'b1, 1'b0);
        end
        sides(1);
        chk("sat_hold", 8'h99, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b111, 1'b0);
        chk("mid_reset", 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
